ureg: RTL and testbench

Parametrised universal register: the next-generation storage element after the single-bit set/reset/enable flip-flop, generalised to WIDTH bits with a synchronous set, a clock enable, and an operation selector for load, shift, rotate, increment and decrement. It is the common building block for counters, shift chains and loadable state registers across the chapter designs, and sits directly between datapath logic and any consumer of a registered word.

---
 rtl/ureg_pkg.sv | 21 ++
 rtl/ureg_next.sv | 102 ++++++++++
 rtl/ureg.sv | 55 +++++
 tb/tb_ureg.sv | 170 +++++++++++++++++
 4 files changed

// File: rtl/ureg_pkg.sv
// Shared types and constants for the universal register.
// Holds the operation encoding used by ureg and ureg_next.
// No logic lives here; types and widths only.
package ureg_pkg;

   // Width of the operation selector.
   localparam int OP_W = 3;

   // Operation encoding applied when the register is enabled.
   typedef enum logic [OP_W-1:0] {
      OP_HOLD = 3'd0,
      OP_LOAD = 3'd1,
      OP_SHL  = 3'd2,
      OP_SHR  = 3'd3,
      OP_ROL  = 3'd4,
      OP_ROR  = 3'd5,
      OP_INC  = 3'd6,
      OP_DEC  = 3'd7
   } ureg_op_e;

endpackage

// File: rtl/ureg_next.sv
// Next-state datapath for ureg: computes {co_next, q_next} from q, co, d, si, op.
// Latency: purely combinational, zero cycles.
// No flow control; optional saturation of INC/DEC when UREG_SAT_EN is defined.
import ureg_pkg::*;

module ureg_next #(
   parameter int WIDTH = 8
) (
   input  logic [WIDTH-1:0] q,
   input  logic             co,
   input  logic [WIDTH-1:0] d,
   input  logic             si,
   input  logic [OP_W-1:0]  op,
   output logic [WIDTH-1:0] q_next,
   output logic             co_next
);

   ureg_op_e   op_sel;
   logic [WIDTH:0] inc_sum;
   logic [WIDTH:0] dec_dif;
   logic           q_all_ones;
   logic           q_is_zero;

   assign op_sel = ureg_op_e'(op);

   // Arithmetic is done one bit wider so the top bit is the carry/borrow.
   assign inc_sum    = {1'b0, q} + {{WIDTH{1'b0}}, 1'b1};
   assign dec_dif    = {1'b0, q} - {{WIDTH{1'b0}}, 1'b1};
   assign q_all_ones = &q;
   assign q_is_zero  = ~|q;

   // Select the next register word and flag; si is only consulted by SHL/SHR
   // so an unknown si cannot leak into other operations.
   always_comb begin
      q_next  = q;
      co_next = co;
      case (op_sel)
         OP_HOLD: begin
            q_next  = q;
            co_next = co;
         end
         OP_LOAD: begin
            q_next  = d;
            co_next = 1'b0;
         end
         OP_SHL: begin
            q_next  = {q[WIDTH-2:0], si};
            co_next = q[WIDTH-1];
         end
         OP_SHR: begin
            q_next  = {si, q[WIDTH-1:1]};
            co_next = q[0];
         end
         OP_ROL: begin
            q_next  = {q[WIDTH-2:0], q[WIDTH-1]};
            co_next = q[WIDTH-1];
         end
         OP_ROR: begin
            q_next  = {q[0], q[WIDTH-1:1]};
            co_next = q[0];
         end
`ifdef UREG_SAT_EN
         // Saturating count: stick at all-ones and flag the attempted overflow.
         OP_INC: begin
            if (q_all_ones) begin
               q_next  = q;
               co_next = 1'b1;
            end else begin
               q_next  = inc_sum[WIDTH-1:0];
               co_next = 1'b0;
            end
         end
         // Saturating count: stick at zero and flag the attempted underflow.
         OP_DEC: begin
            if (q_is_zero) begin
               q_next  = q;
               co_next = 1'b1;
            end else begin
               q_next  = dec_dif[WIDTH-1:0];
               co_next = 1'b0;
            end
         end
`else
         // Wrapping count: the extra top bit is the carry out.
         OP_INC: begin
            q_next  = inc_sum[WIDTH-1:0];
            co_next = inc_sum[WIDTH] | (q_all_ones & 1'b0);
         end
         // Wrapping count: borrow exactly when the old value was zero.
         OP_DEC: begin
            q_next  = dec_dif[WIDTH-1:0];
            co_next = dec_dif[WIDTH] | (q_is_zero & 1'b0);
         end
`endif
         default: begin
            q_next  = q;
            co_next = co;
         end
      endcase
   end

endmodule

// File: rtl/ureg.sv
// Universal WIDTH-bit register: load/shift/rotate/inc/dec with sync rst, set and enable.
// Latency: one cycle from sampled inputs to q/co; zero follows q combinationally.
// No backpressure: accepts a new op every cycle; e low holds. Option macro: UREG_SAT_EN.
import ureg_pkg::*;

module ureg #(
   parameter int               WIDTH   = 8,
   parameter logic [WIDTH-1:0] RST_VAL = '0,
   parameter logic [WIDTH-1:0] SET_VAL = '1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             set,
   input  logic             e,
   input  logic [OP_W-1:0]  op,
   input  logic [WIDTH-1:0] d,
   input  logic             si,
   output logic [WIDTH-1:0] q,
   output logic             co,
   output logic             zero
);

   logic [WIDTH-1:0] q_next;
   logic             co_next;

   ureg_next #(
      .WIDTH (WIDTH)
   ) u_next (
      .q       (q),
      .co      (co),
      .d       (d),
      .si      (si),
      .op      (op),
      .q_next  (q_next),
      .co_next (co_next)
   );

   // Storage with priority rst > set > enable; rst and set bypass the enable.
   always_ff @(posedge clk) begin
      if (rst) begin
         q  <= RST_VAL;
         co <= 1'b0;
      end else if (set) begin
         q  <= SET_VAL;
         co <= 1'b0;
      end else if (e) begin
         q  <= q_next;
         co <= co_next;
      end
   end

   // Zero flag looks at the stored word only, never at co.
   assign zero = ~|q;

endmodule

// File: tb/tb_ureg.sv
// Self-checking bench for ureg at WIDTH=8, RST_VAL=0, SET_VAL=0xFF.
// Directed test-plan steps followed by a randomized run against an arithmetic model.
// Honours UREG_SAT_EN in the model when defined.
`timescale 1ns/1ps
import ureg_pkg::*;

module tb_ureg;

   logic       clk;
   logic       rst;
   logic       set;
   logic       e;
   logic [2:0] op;
   logic [7:0] d;
   logic       si;
   logic [7:0] q;
   logic       co;
   logic       zero;

   int checks   = 0;
   int failures = 0;

   // Reference state held as plain integers.
   int m_q  = 0;
   int m_co = 0;

`ifdef UREG_SAT_EN
   localparam bit SAT = 1'b1;
`else
   localparam bit SAT = 1'b0;
`endif

   ureg #(
      .WIDTH   (8),
      .RST_VAL (8'h00),
      .SET_VAL (8'hFF)
   ) dut (
      .clk  (clk),
      .rst  (rst),
      .set  (set),
      .e    (e),
      .op   (op),
      .d    (d),
      .si   (si),
      .q    (q),
      .co   (co),
      .zero (zero)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Behavioural model: one rising edge expressed as integer arithmetic.
   task automatic model(input bit r, input bit s, input bit en, input int o,
                        input int dv, input int sv);
      int nq;
      if (r) begin
         m_q = 0; m_co = 0;
      end else if (s) begin
         m_q = 255; m_co = 0;
      end else if (en) begin
         case (o)
            1: begin m_q = dv; m_co = 0; end
            2: begin nq = (m_q * 2 + sv) % 256;        m_co = m_q / 128; m_q = nq; end
            3: begin nq = m_q / 2 + sv * 128;          m_co = m_q % 2;   m_q = nq; end
            4: begin nq = (m_q * 2) % 256 + m_q / 128; m_co = m_q / 128; m_q = nq; end
            5: begin nq = m_q / 2 + (m_q % 2) * 128;   m_co = m_q % 2;   m_q = nq; end
            6: begin
               if (SAT && m_q == 255) m_co = 1;
               else begin m_co = (m_q + 1) / 256; m_q = (m_q + 1) % 256; end
            end
            7: begin
               if (SAT && m_q == 0) m_co = 1;
               else begin m_co = (m_q == 0) ? 1 : 0; m_q = (m_q + 255) % 256; end
            end
            default: ;
         endcase
      end
   endtask

   // Drive one cycle of inputs, advance the model, then compare after the edge.
   task automatic step(input string tag, input bit r, input bit s, input bit en,
                       input int o, input int dv, input logic sv);
      rst = r; set = s; e = en; op = 3'(o); d = 8'(dv); si = sv;
      model(r, s, en, o, dv, (sv === 1'b1) ? 1 : 0);
      @(posedge clk);
      #1;
      chk({tag, ".q"},    q,          8'(m_q));
      chk({tag, ".co"},   {7'b0, co}, 8'(m_co));
      chk({tag, ".zero"}, {7'b0, zero}, (m_q == 0) ? 8'h01 : 8'h00);
   endtask

   initial begin
      rst = 1'b0; set = 1'b0; e = 1'b0; op = 3'd0; d = 8'h00; si = 1'b0;

      // rst and set together with a pending LOAD: rst wins.
      step("rst_set", 1, 1, 1, OP_LOAD, 8'h5A, 1'b0);
      chk("rst_lit", q, 8'h00);

      // Overflow on INC.
      step("ld_ff", 0, 0, 1, OP_LOAD, 8'hFF, 1'b0);
      step("inc_ovf", 0, 0, 1, OP_INC, 0, 1'b0);
      chk("inc_ovf_lit", q, SAT ? 8'hFF : 8'h00);
      chk("inc_ovf_co", {7'b0, co}, 8'h01);

      // Shifts with serial input.
      step("ld_81", 0, 0, 1, OP_LOAD, 8'h81, 1'b0);
      step("shl", 0, 0, 1, OP_SHL, 0, 1'b0);
      chk("shl_lit", q, 8'h02);
      step("shr", 0, 0, 1, OP_SHR, 0, 1'b1);
      chk("shr_lit", q, 8'h81);

      // Rotates ignore si, even when it is unknown.
      step("ld_01", 0, 0, 1, OP_LOAD, 8'h01, 1'bx);
      step("ror", 0, 0, 1, OP_ROR, 0, 1'bx);
      chk("ror_lit", q, 8'h80);
      step("rol", 0, 0, 1, OP_ROL, 0, 1'bx);
      chk("rol_lit", q, 8'h01);

      // Enable low holds q and co regardless of op.
      step("ld_10", 0, 0, 1, OP_LOAD, 8'h10, 1'b0);
      for (int i = 0; i < 3; i++) step("e0_dec", 0, 0, 0, OP_DEC, 0, 1'b0);
      chk("e0_hold_lit", q, 8'h10);
      step("dec", 0, 0, 1, OP_DEC, 0, 1'b0);
      chk("dec_lit", q, 8'h0F);
      step("ld_00", 0, 0, 1, OP_LOAD, 8'h00, 1'b0);
      step("dec_unf", 0, 0, 1, OP_DEC, 0, 1'b0);
      chk("dec_unf_lit", q, SAT ? 8'h00 : 8'hFF);
      chk("dec_unf_co", {7'b0, co}, 8'h01);
      step("e0_co_hold", 0, 0, 0, OP_LOAD, 8'h33, 1'b0);

      // Count interrupted by rst, then resumes from RST_VAL.
      step("cnt_clr", 0, 0, 1, OP_LOAD, 8'h00, 1'b0);
      step("cnt1", 0, 0, 1, OP_INC, 0, 1'b0);
      step("cnt2", 0, 0, 1, OP_INC, 0, 1'b0);
      step("cnt_rst", 1, 0, 1, OP_INC, 0, 1'b0);
      chk("cnt_rst_lit", q, 8'h00);
      step("cnt_resume", 0, 0, 1, OP_INC, 0, 1'b0);
      chk("cnt_resume_lit", q, 8'h01);
      step("cnt3", 0, 0, 1, OP_INC, 0, 1'b0);

      // set is not gated by the enable.
      step("set_e0", 0, 1, 0, OP_INC, 0, 1'b0);
      chk("set_e0_lit", q, 8'hFF);

      // Randomized run: rare rst/set, mostly enabled, any op.
      for (int i = 0; i < 1500; i++) begin
         step("rand",
              ($urandom_range(0, 31) == 0),
              ($urandom_range(0, 31) == 0),
              ($urandom_range(0, 3) != 0),
              int'($urandom_range(0, 7)),
              int'($urandom_range(0, 255)),
              logic'($urandom_range(0, 1)));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
